// File: rtl/rom_load_sched.sv
// rom_load_sched
//   Packs a byte-wide ROM download stream into 16-bit words, decodes each word
//   address into one of four memory regions, buffers up to four words and
//   writes them one at a time through a request/acknowledge memory port.
//
// Ports
//   clk       system clock, rising edge
//   nreset    asynchronous active-low reset
//   dl_en     download session active (level)
//   dl_wr     byte write strobe, qualified by dl_en
//   dl_addr   byte address of dl_data
//   dl_data   download byte
//   dl_wait   backpressure to host (buffer holds three or more words)
//   mem_req   write request to shared memory port
//   mem_sel   target region index
//   mem_addr  word offset within the region
//   mem_data  word to write
//   mem_ack   one-cycle acknowledge of the current request
//   done      session complete, every word written
//   err       sticky buffer overflow flag
module rom_load_sched #(
    parameter int              AW      = 24,
    parameter logic [AW-1:0]   R1_BASE = 24'h080000,
    parameter logic [AW-1:0]   R2_BASE = 24'h100000,
    parameter logic [AW-1:0]   R3_BASE = 24'h200000
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          dl_en,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic          mem_req,
    output logic [1:0]    mem_sel,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_data,
    input  logic          mem_ack,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } port_state_t;

    // Filler for the half of a word the host never sent.
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Region index of a byte address; the highest base that is not above it wins.
    function automatic logic [1:0] region_sel(input logic [AW-1:0] a);
        logic [1:0] s;
        if (a >= R3_BASE) begin
            s = 2'd3;
        end else if (a >= R2_BASE) begin
            s = 2'd2;
        end else if (a >= R1_BASE) begin
            s = 2'd1;
        end else begin
            s = 2'd0;
        end
        return s;
    endfunction

    // Word offset of a byte address inside its region; wrap is not checked.
    function automatic logic [AW-2:0] region_off(input logic [AW-1:0] a);
        logic [AW-1:0] base;
        logic [AW-1:0] diff;
        case (region_sel(a))
            2'd3:    base = R3_BASE;
            2'd2:    base = R2_BASE;
            2'd1:    base = R1_BASE;
            default: base = {AW{1'b0}};
        endcase
        diff = a - base;
        return diff[AW-1:1];
    endfunction

    // Download-side state
    logic          dl_en_d_r;
    logic          pend_vld_r;
    logic [AW-1:0] pend_addr_r;
    logic [7:0]    pend_data_r;

    // Word buffer
    logic [3:0][1:0]    fifo_sel_r;
    logic [3:0][AW-2:0] fifo_addr_r;
    logic [3:0][15:0]   fifo_data_r;
    logic [1:0]         wr_ptr_r;
    logic [1:0]         rd_ptr_r;
    logic [2:0]         count_r;

    // Port side and status
    port_state_t   state_r;
    logic          mem_req_r;
    logic [1:0]    mem_sel_r;
    logic [AW-2:0] mem_addr_r;
    logic [15:0]   mem_data_r;
    logic          dl_wait_r;
    logic          done_r;
    logic          err_r;

    // Combinational controls
    logic          rise_s;
    logic          pend_live_s;
    logic [AW-1:0] even_addr_s;
    logic          push_s;
    logic [AW-1:0] push_baddr_s;
    logic [15:0]   push_data_s;
    logic          pend_set_s;
    logic          pend_clr_s;
    logic          full_s;
    logic          push_ok_s;
    logic          ovf_s;
    logic          pop_s;
    logic [2:0]    count_nxt_s;

    assign rise_s      = dl_en & ~dl_en_d_r;
    // A session start discards any byte left from before.
    assign pend_live_s = pend_vld_r & ~rise_s;
    assign even_addr_s = {dl_addr[AW-1:1], 1'b0};

    // Byte packer: decides what, if anything, is pushed this cycle.
    always_comb begin
        push_s       = 1'b0;
        push_baddr_s = pend_addr_r;
        push_data_s  = {pend_data_r, FILL_BYTE};
        pend_set_s   = 1'b0;
        pend_clr_s   = 1'b0;
        if (!dl_en) begin
            // Session closed: flush a lone high byte.
            if (pend_vld_r) begin
                push_s     = 1'b1;
                pend_clr_s = 1'b1;
            end else begin
                push_s     = 1'b0;
            end
        end else if (dl_wr) begin
            if (!dl_addr[0]) begin
                // New high byte; an older pending byte goes out padded.
                pend_set_s = 1'b1;
                if (pend_live_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end else if (pend_live_s && (pend_addr_r == even_addr_s)) begin
                push_s      = 1'b1;
                push_data_s = {pend_data_r, dl_data};
                pend_clr_s  = 1'b1;
            end else begin
                // Orphan low byte; an unrelated pending byte is left in place.
                push_s       = 1'b1;
                push_baddr_s = even_addr_s;
                push_data_s  = {FILL_BYTE, dl_data};
            end
        end else begin
            push_s = 1'b0;
        end
    end

    assign full_s    = (count_r == 3'd4);
    assign push_ok_s = push_s & ~full_s;
    assign ovf_s     = push_s & full_s;
    assign pop_s     = (state_r == ST_REQ) & mem_ack;

    // Next buffer occupancy.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + 3'd1;
            2'b01:   count_nxt_s = count_r - 3'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pending high byte and session-enable history.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dl_en_d_r   <= 1'b0;
            pend_vld_r  <= 1'b0;
            pend_addr_r <= {AW{1'b0}};
            pend_data_r <= 8'h00;
        end else begin
            dl_en_d_r <= dl_en;
            if (pend_set_s) begin
                pend_vld_r  <= 1'b1;
                pend_addr_r <= dl_addr;
                pend_data_r <= dl_data;
            end else if (pend_clr_s || rise_s) begin
                pend_vld_r  <= 1'b0;
            end else begin
                pend_vld_r  <= pend_vld_r;
            end
        end
    end

    // Word buffer storage, pointers, occupancy and backpressure.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fifo_sel_r  <= '0;
            fifo_addr_r <= '0;
            fifo_data_r <= '0;
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            dl_wait_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_sel_r[wr_ptr_r]  <= region_sel(push_baddr_s);
                fifo_addr_r[wr_ptr_r] <= region_off(push_baddr_s);
                fifo_data_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r              <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r   <= count_nxt_s;
            dl_wait_r <= (count_nxt_s >= 3'd3);
        end
    end

    // Status flags: sticky overflow and session-complete.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (rise_s) begin
                err_r <= ovf_s;
            end else if (ovf_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (rise_s) begin
                done_r <= 1'b0;
            end else if (!dl_en && !pend_vld_r && (count_r == 3'd0) && (state_r == ST_IDLE)) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    // Memory port FSM; the head entry is held on the port until acknowledged.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_sel_r  <= 2'd0;
            mem_addr_r <= {(AW-1){1'b0}};
            mem_data_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != 3'd0) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_sel_r  <= fifo_sel_r[rd_ptr_r];
                        mem_addr_r <= fifo_addr_r[rd_ptr_r];
                        mem_data_r <= fifo_data_r[rd_ptr_r];
                    end else begin
                        mem_req_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_r   <= ST_GAP;
                        mem_req_r <= 1'b0;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign dl_wait  = dl_wait_r;
    assign mem_req  = mem_req_r;
    assign mem_sel  = mem_sel_r;
    assign mem_addr = mem_addr_r;
    assign mem_data = mem_data_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_rom_load_sched.sv
// tb_rom_load_sched
//   Scoreboard bench for rom_load_sched: expected words are queued as bytes
//   are driven and compared when the memory port handshake completes.
module tb_rom_load_sched;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          nreset;
    logic          dl_en;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic          mem_req;
    logic [1:0]    mem_sel;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_ack;
    logic          done;
    logic          err;

    rom_load_sched #(.AW(AW)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .dl_en    (dl_en),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .dl_wait  (dl_wait),
        .mem_req  (mem_req),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];
    bit          ack_en = 1'b0;
    bit          low_seen = 1'b1;
    int          req_hi_cnt = 0;

    function automatic logic [63:0] pack(input logic [1:0] s, input logic [AW-2:0] a, input logic [15:0] d);
        return {23'd0, s, a, d};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_push(input logic [1:0] s, input logic [AW-2:0] a, input logic [15:0] d);
        exp_q.push_back(pack(s, a, d));
    endtask

    // One-cycle byte strobe, called at a falling edge.
    task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(negedge clk);
        dl_wr   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1);
        check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Memory responder and monitor: acks one cycle after mem_req and checks the word.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                req_hi_cnt++;
            end else begin
                low_seen = 1'b1;
            end
            if (nreset && ack_en && mem_req) begin
                check_eq("req_gap", low_seen, 1);
                low_seen = 1'b0;
                check_eq("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("mem_word", pack(mem_sel, mem_addr, mem_data), exp_q.pop_front());
                end
                mem_ack = 1'b1;
            end
        end
    end

    initial begin
        int n;
        logic [AW-1:0] a;
        nreset  = 1'b0;
        dl_en   = 1'b0;
        dl_wr   = 1'b0;
        dl_addr = '0;
        dl_data = 8'h00;
        tick(2);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_dl_wait", dl_wait, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mem_sel", mem_sel, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_data", mem_data, 0);
        nreset = 1'b1;
        tick(2);
        check_eq("idle_done", done, 1);
        ack_en = 1'b1;

        // Simple pair in region 0
        dl_en = 1'b1;
        tick(1);
        check_eq("done_clr", done, 0);
        exp_push(2'd0, 23'd0, 16'h1234);
        wr_byte(24'h000000, 8'h12);
        wr_byte(24'h000001, 8'h34);
        dl_en = 1'b0;
        wait_done("pair_r0_done");

        // Pair in region 2
        dl_en = 1'b1;
        tick(1);
        exp_push(2'd2, 23'd1, 16'hABCD);
        wr_byte(24'h100002, 8'hAB);
        wr_byte(24'h100003, 8'hCD);
        dl_en = 1'b0;
        wait_done("pair_r2_done");

        // Lone even byte flushed at session end
        dl_en = 1'b1;
        tick(1);
        exp_push(2'd0, 23'd2, 16'h55FF);
        wr_byte(24'h000004, 8'h55);
        dl_en = 1'b0;
        wait_done("flush_done");

        // Orphan odd byte, then even byte displacing a pending one
        dl_en = 1'b1;
        tick(1);
        exp_push(2'd1, 23'd1, 16'hFF77);
        wr_byte(24'h080003, 8'h77);
        exp_push(2'd3, 23'd0, 16'h11FF);
        wr_byte(24'h200000, 8'h11);
        wr_byte(24'h200004, 8'h22);
        exp_push(2'd3, 23'd2, 16'h2233);
        wr_byte(24'h200005, 8'h33);
        dl_en = 1'b0;
        wait_done("mixed_done");
        check_eq("mixed_err", err, 0);

        // Overflow: ten pairs with ack withheld
        ack_en = 1'b0;
        dl_en  = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            a = 24'h000100 + 24'(2 * i);
            if (i < 4) begin
                exp_push(2'd0, 23'(a >> 1), {8'(8'h10 + i), 8'(8'h80 + i)});
            end
            wr_byte(a, 8'(8'h10 + i));
            wr_byte(a + 24'd1, 8'(8'h80 + i));
            check_eq($sformatf("ovf_wait_%0d", i), dl_wait, (i >= 2) ? 1 : 0);
            check_eq($sformatf("ovf_err_%0d", i), err, (i >= 4) ? 1 : 0);
        end
        ack_en = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ovf_drained", exp_q.size(), 0);
        dl_en = 1'b0;
        wait_done("ovf_done");
        check_eq("ovf_err_sticky", err, 1);
        dl_en = 1'b1;
        tick(1);
        check_eq("rise_err_clr", err, 0);
        check_eq("rise_done_clr", done, 0);

        // Reset in the middle of a transaction with three words queued
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 24'h100010 + 24'(2 * i);
            wr_byte(a, 8'(8'h40 + i));
            wr_byte(a + 24'd1, 8'(8'h60 + i));
        end
        tick(3);
        check_eq("mid_mem_req", mem_req, 1);
        check_eq("mid_dl_wait", dl_wait, 1);
        nreset = 1'b0;
        #1;
        check_eq("async_mem_req", mem_req, 0);
        check_eq("async_dl_wait", dl_wait, 0);
        exp_q.delete();
        tick(2);
        nreset     = 1'b1;
        req_hi_cnt = 0;
        ack_en     = 1'b1;
        tick(20);
        check_eq("post_rst_reqs", req_hi_cnt, 0);
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_err", err, 0);
        dl_en = 1'b0;
        wait_done("post_rst_final");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
